// File: rtl/rv_pkg_v.sv
// Shared RV32I definitions for the MEM stage: funct3 codes,
// FSM state encodings and the MEM/WB register bundle.
package rv_pkg_v;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  typedef struct packed {
    logic        is_valid;
    logic        reg_write;
    logic        misaligned;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
  } mem_wb_t;

endpackage

// File: rtl/load_align_v.sv
// Load extraction: shifts the read word down to its byte lane and
// sign/zero-extends. In: rdata, a, funct3. Out: data, illegal.
module load_align_v (
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        illegal
);
  import rv_pkg_v::*;

  logic [31:0] sh;

  always_comb begin
    sh      = rdata >> {a, 3'b000};
    data    = '0;
    illegal = 1'b0;
    unique case (funct3)
      F3_LB:   data = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   data = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   data = sh;
      F3_LBU:  data = {24'b0, sh[7:0]};
      F3_LHU:  data = {16'b0, sh[15:0]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_v.sv
// MEM stage: issues loads/stores over a req/ack data-memory port,
// stalls upstream while waiting and registers the MEM/WB bundle.
// In: EX/MEM bundle, dmem_ack/rdata. Out: mem_stall, dmem_*, wb_*.
module mem_stage_v #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_isValid,
  input  logic [31:0]       mem_pc,
  input  logic [31:0]       mem_instr,
  input  logic [4:0]        mem_rd,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic              mem_reg_write,
  input  logic [31:0]       mem_result,
  input  logic [31:0]       mem_sData,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_isValid,
  output logic              wb_reg_write,
  output logic              wb_misaligned,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_instr,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd
);
  import rv_pkg_v::*;

  logic        state_q, state_d;
  mem_wb_t     wb_q, wb_d;

  logic [1:0]  a;
  logic [2:0]  f3;
  logic        is_mem, is_st, is_ld;
  logic        st_mis, ld_mis, mis;
  logic        ld_ill;
  logic [31:0] ld_data;

  assign a  = mem_result[1:0];
  assign f3 = mem_instr[14:12];

  load_align_v u_load_align (
    .rdata   (dmem_rdata),
    .a       (a),
    .funct3  (f3),
    .data    (ld_data),
    .illegal (ld_ill)
  );

  // Read+write together is a store.
  always_comb begin
    is_mem = mem_isValid & (mem_mem_read | mem_mem_write);
    is_st  = is_mem & mem_mem_write;
    is_ld  = is_mem & ~mem_mem_write;
    st_mis = (f3 == F3_SH & a[0])
           | (f3 == F3_SW & |a)
           | (f3 > F3_SW);
    ld_mis = ld_ill
           | (f3[1:0] == 2'b01 & a[0])
           | (f3 == F3_LW & |a);
    mis    = is_st ? st_mis : ld_mis;
  end

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_sData;
    if (is_st) begin
      unique case (f3)
        F3_SB: begin
          dmem_be    = 4'b0001 << a;
          dmem_wdata = {4{mem_sData[7:0]}};
        end
        F3_SH: begin
          dmem_be    = 4'b0011 << a;
          dmem_wdata = {2{mem_sData[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign dmem_we   = is_st;
  assign dmem_addr = {mem_result[ADDR_W-1:2], 2'b00};
  assign dmem_req  = ~reset
                   & ((state_q == S_WAIT)
                   | (is_mem & ~mis));
  assign mem_stall = dmem_req & ~dmem_ack;

  // A request without ack waits; anything else returns to IDLE.
  assign state_d = mem_stall ? S_WAIT : S_IDLE;

  always_comb begin
    wb_d = wb_q;
    if (!mem_stall) begin
      unique case (1'b1)
        !mem_isValid: begin
          wb_d.is_valid  = 1'b0;
          wb_d.reg_write = 1'b0;
        end
        is_mem & mis: begin
          wb_d.is_valid   = 1'b1;
          wb_d.reg_write  = 1'b0;
          wb_d.misaligned = 1'b1;
          wb_d.pc         = mem_pc;
          wb_d.instr      = mem_instr;
          wb_d.rd         = mem_rd;
          wb_d.data       = mem_result;
        end
        is_st & ~mis: begin
          wb_d.is_valid   = 1'b1;
          wb_d.reg_write  = 1'b0;
          wb_d.misaligned = 1'b0;
          wb_d.pc         = mem_pc;
          wb_d.instr      = mem_instr;
          wb_d.rd         = mem_rd;
          wb_d.data       = mem_result;
        end
        is_ld & ~mis: begin
          wb_d.is_valid   = 1'b1;
          wb_d.reg_write  = mem_reg_write;
          wb_d.misaligned = 1'b0;
          wb_d.pc         = mem_pc;
          wb_d.instr      = mem_instr;
          wb_d.rd         = mem_rd;
          wb_d.data       = ld_data;
        end
        default: begin
          wb_d.is_valid   = 1'b1;
          wb_d.reg_write  = mem_reg_write;
          wb_d.misaligned = 1'b0;
          wb_d.pc         = mem_pc;
          wb_d.instr      = mem_instr;
          wb_d.rd         = mem_rd;
          wb_d.data       = mem_result;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_isValid    = wb_q.is_valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_misaligned = wb_q.misaligned;
  assign wb_pc         = wb_q.pc;
  assign wb_instr      = wb_q.instr;
  assign wb_data       = wb_q.data;
  assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_mem_stage_v.sv
// Randomized self-checking bench for mem_stage_v against a
// behavioural MEM/WB model with directed corner cases first.
module tb_mem_stage_v;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_isValid;
  logic [31:0] mem_pc, mem_instr;
  logic [4:0]  mem_rd;
  logic        mem_mem_read, mem_mem_write, mem_reg_write;
  logic [31:0] mem_result, mem_sData;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_isValid, wb_reg_write, wb_misaligned;
  logic [31:0] wb_pc, wb_instr, wb_data;
  logic [4:0]  wb_rd;

  int n_chk = 0;
  int n_fail = 0;

  logic        e_valid, e_rw, e_mis;
  logic [31:0] e_pc, e_instr, e_data;
  logic [4:0]  e_rd;

  mem_stage_v #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_isValid   (mem_isValid),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_rd        (mem_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .mem_sData     (mem_sData),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_isValid    (wb_isValid),
    .wb_reg_write  (wb_reg_write),
    .wb_misaligned (wb_misaligned),
    .wb_pc         (wb_pc),
    .wb_instr      (wb_instr),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    chk({tag, ".valid"}, 32'(wb_isValid), 32'(e_valid));
    chk({tag, ".rw"}, 32'(wb_reg_write), 32'(e_rw));
    chk({tag, ".mis"}, 32'(wb_misaligned), 32'(e_mis));
    chk({tag, ".pc"}, wb_pc, e_pc);
    chk({tag, ".instr"}, wb_instr, e_instr);
    chk({tag, ".data"}, wb_data, e_data);
    chk({tag, ".rd"}, 32'(wb_rd), 32'(e_rd));
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (8 * a);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return s;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal_op(input logic st,
                                  input logic [2:0] f3,
                                  input logic [1:0] a);
    if (st)
      return f3 == 3'd0
          || (f3 == 3'd1 && a % 2 == 0)
          || (f3 == 3'd2 && a == 0);
    return f3 == 3'd0 || f3 == 3'd4
        || ((f3 == 3'd1 || f3 == 3'd5) && a % 2 == 0)
        || (f3 == 3'd2 && a == 0);
  endfunction

  // Called one time unit after a rising edge; returns likewise.
  task automatic do_op(input logic v, input logic rd_en,
                       input logic wr_en, input logic rw,
                       input logic [2:0] f3,
                       input logic [31:0] res,
                       input logic [31:0] sd,
                       input logic [31:0] rdat,
                       input int waits);
    logic [31:0] pc, instr, ew;
    logic [4:0]  rd;
    logic [3:0]  ebe;
    logic [1:0]  a;
    bit          is_mem, lgl, ereq;
    pc    = $urandom;
    instr = $urandom;
    instr[14:12] = f3;
    rd    = 5'($urandom_range(0, 31));
    a     = res[1:0];
    mem_isValid   = v;
    mem_pc        = pc;
    mem_instr     = instr;
    mem_rd        = rd;
    mem_mem_read  = rd_en;
    mem_mem_write = wr_en;
    mem_reg_write = rw;
    mem_result    = res;
    mem_sData     = sd;
    dmem_ack      = 1'b0;
    is_mem = v && (rd_en || wr_en);
    lgl    = legal_op(wr_en, f3, a);
    ereq   = is_mem && lgl;
    #1;
    chk("req", 32'(dmem_req), 32'(ereq));
    if (ereq) begin
      chk("we", 32'(dmem_we), 32'(wr_en));
      chk("addr", dmem_addr, res & ~32'd3);
      ebe = 4'b1111;
      ew  = sd;
      if (wr_en && f3 == 3'd0) begin
        ebe = 4'b0001 << a;
        ew  = (sd % 256) * 32'h0101_0101;
      end
      if (wr_en && f3 == 3'd1) begin
        ebe = 4'b0011 << a;
        ew  = (sd % 65536) * 32'h0001_0001;
      end
      chk("be", 32'(dmem_be), 32'(ebe));
      if (wr_en) chk("wdata", dmem_wdata, ew);
      for (int i = 0; i < waits; i++) begin
        chk("stall", 32'(mem_stall), 32'd1);
        @(posedge clk);
        #1;
        chk("hold.valid", 32'(wb_isValid), 32'(e_valid));
        chk("hold.data", wb_data, e_data);
        chk("wait.req", 32'(dmem_req), 32'd1);
      end
      dmem_ack = 1'b1;
    end else begin
      dmem_ack = 1'($urandom_range(0, 1));
    end
    dmem_rdata = rdat;
    #1;
    chk("nostall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    if (!v) begin
      e_valid = 1'b0;
      e_rw    = 1'b0;
    end else begin
      e_valid = 1'b1;
      e_pc    = pc;
      e_instr = instr;
      e_rd    = rd;
      e_mis   = 1'b0;
      e_data  = res;
      e_rw    = rw;
      if (is_mem && !lgl) begin
        e_rw  = 1'b0;
        e_mis = 1'b1;
      end else if (is_mem && wr_en) begin
        e_rw = 1'b0;
      end else if (is_mem) begin
        e_data = load_val(f3, a, rdat);
      end
    end
    check_wb("wb");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] res;
    int          kind;
    reset         = 1'b1;
    mem_isValid   = 1'b1;
    mem_pc        = '0;
    mem_instr     = 32'h0000_2003;
    mem_rd        = 5'd1;
    mem_mem_read  = 1'b1;
    mem_mem_write = 1'b0;
    mem_reg_write = 1'b1;
    mem_result    = 32'h100;
    mem_sData     = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    {e_valid, e_rw, e_mis} = '0;
    {e_pc, e_instr, e_data} = '0;
    e_rd = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    check_wb("rst");
    reset = 1'b0;

    do_op(1, 1, 0, 1, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 0);
    chk("lw0.data", wb_data, 32'hDEAD_BEEF);
    chk("lw0.rw", 32'(wb_reg_write), 32'd1);
    do_op(1, 1, 0, 1, 3'd0, 32'h103, 0, 32'h80FF_0000, 3);
    chk("lb.data", wb_data, 32'hFFFF_FF80);
    do_op(1, 1, 0, 1, 3'd4, 32'h103, 0, 32'h80FF_0000, 3);
    chk("lbu.data", wb_data, 32'h0000_0080);
    do_op(1, 0, 1, 1, 3'd1, 32'h102, 32'h0000_ABCD, 0, 1);
    chk("sh.rw", 32'(wb_reg_write), 32'd0);
    do_op(1, 1, 0, 1, 3'd2, 32'h101, 0, 32'h1234_5678, 2);
    chk("mis.flag", 32'(wb_misaligned), 32'd1);
    chk("mis.rw", 32'(wb_reg_write), 32'd0);

    mem_isValid   = 1'b1;
    mem_mem_read  = 1'b1;
    mem_mem_write = 1'b0;
    mem_instr     = 32'h0000_2003;
    mem_result    = 32'h200;
    dmem_ack      = 1'b0;
    #1;
    chk("rw.req", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    chk("rw.wait", 32'(mem_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("rw.rreq", 32'(dmem_req), 32'd0);
    chk("rw.rstall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    mem_isValid = 1'b0;
    dmem_ack    = 1'b1;
    {e_valid, e_rw, e_mis} = '0;
    {e_pc, e_instr, e_data} = '0;
    e_rd = '0;
    #1;
    chk("rw.req2", 32'(dmem_req), 32'd0);
    chk("rw.stall2", 32'(mem_stall), 32'd0);
    check_wb("rw");
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check_wb("rw2");

    do_op(1, 0, 1, 1, 3'd2, 32'h40, 32'h55, 0, 0);
    chk("b2b.st", 32'(wb_reg_write), 32'd0);
    do_op(1, 0, 0, 1, 3'd0, 32'd7, 0, 0, 0);
    chk("b2b.add", wb_data, 32'd7);
    do_op(0, 0, 0, 1, 3'd0, 32'd9, 0, 0, 0);
    chk("b2b.inv", 32'(wb_isValid), 32'd0);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      res  = $urandom;
      if (kind == 0) begin
        do_op(0, 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), res, $urandom, $urandom, 0);
      end else if (kind <= 3) begin
        do_op(1, 0, 0, 1'($urandom), 3'($urandom),
              res, $urandom, $urandom, 0);
      end else if (kind <= 6) begin
        f3 = 3'($urandom_range(0, 7));
        do_op(1, 1, 0, 1'($urandom), f3, res,
              $urandom, $urandom, $urandom_range(0, 3));
      end else begin
        f3 = 3'($urandom_range(0, 2));
        do_op(1, 1'($urandom), 1, 1'($urandom), f3, res,
              $urandom, $urandom, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
